// File: rtl/uart_alu_if.sv
// Host-side client of the uart FIFO interface: pops an {A, B, opcode} frame, lets an
// external combinational ALU evaluate it and pushes the one-byte result back out.
module uart_alu_if #(
   parameter int DBIT    = 8,
   parameter int OP_W    = 6,
   parameter int TIMEOUT = 1000,
   parameter int TO_BITS = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_empty,
   input  logic [DBIT-1:0] r_data,
   output logic            rd_uart,
   input  logic            tx_full,
   output logic            wr_uart,
   output logic [DBIT-1:0] w_data,
   input  logic [DBIT-1:0] alu_result,
   output logic [DBIT-1:0] op_a,
   output logic [DBIT-1:0] op_b,
   output logic [OP_W-1:0] op_code,
   output logic            busy,
   output logic            frame_err
);

   localparam logic [2:0] S_A    = 3'd0;
   localparam logic [2:0] S_B    = 3'd1;
   localparam logic [2:0] S_OP   = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_SEND = 3'd4;

   localparam int               TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_LAST_I);

   logic [2:0]         state, state_nx;
   logic [TO_BITS-1:0] cnt;
   logic               in_rx, in_mid, pop, push, to_hit;

   assign in_rx  = (state == S_A) || (state == S_B) || (state == S_OP);
   assign in_mid = (state == S_B) || (state == S_OP);
   assign pop    = in_rx & ~rx_empty;
   assign push   = (state == S_SEND) & ~tx_full;

   // Strobes are masked while reset is held so nothing is consumed during reset.
   assign rd_uart = reset & pop;
   assign wr_uart = reset & push;
   assign busy    = (state != S_A);

   // A byte arriving on the last allowed cycle wins over the timeout.
   assign to_hit = (TIMEOUT != 0) && in_mid && rx_empty && (cnt == TO_LAST);

   always_comb begin
      state_nx = state;
      case (state)
         S_A:     if (!rx_empty) state_nx = S_B;
         S_B:     if (!rx_empty) state_nx = S_OP;
                  else if (to_hit) state_nx = S_A;
         S_OP:    if (!rx_empty) state_nx = S_EXEC;
                  else if (to_hit) state_nx = S_A;
         S_EXEC:  state_nx = S_SEND;
         S_SEND:  if (!tx_full) state_nx = S_A;
         default: state_nx = S_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_A;
         cnt       <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         frame_err <= to_hit;
         if (TIMEOUT == 0)
            cnt <= '0;
         else if (pop || state_nx == S_A)
            cnt <= '0;
         else if (in_mid && rx_empty)
            cnt <= cnt + 1'b1;
      end
   end

   // Operands survive a send or a dropped frame; only a new pop overwrites them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_a    <= '0;
         op_b    <= '0;
         op_code <= '0;
         w_data  <= '0;
      end else begin
         if (pop && state == S_A)  op_a    <= r_data;
         if (pop && state == S_B)  op_b    <= r_data;
         if (pop && state == S_OP) op_code <= r_data[OP_W-1:0];
         if (state == S_EXEC)      w_data  <= alu_result;
      end
   end

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed bench for uart_alu_if: FIFO models around one TIMEOUT=1000 instance and
// one TIMEOUT=0 instance, a small reference ALU, and a vector table plus corner sequences.
module tb_uart_alu_if;

   localparam int TO = 1000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_empty = 1'b1, tx_full = 1'b0, rd_uart, wr_uart, busy, frame_err;
   logic [7:0] r_data = 8'h00, w_data, alu_res, op_a, op_b;
   logic [5:0] op_code;
   logic       rx_empty0 = 1'b1, tx_full0 = 1'b0, rd_uart0, wr_uart0, busy0, frame_err0;
   logic [7:0] r_data0 = 8'h00, w_data0, alu_res0, op_a0, op_b0;
   logic [5:0] op_code0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_res  = alu(op_a, op_b, op_code);
   assign alu_res0 = alu(op_a0, op_b0, op_code0);

   uart_alu_if #(.DBIT(8), .OP_W(6), .TIMEOUT(TO), .TO_BITS(10)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .alu_result(alu_res),
      .op_a(op_a), .op_b(op_b), .op_code(op_code), .busy(busy), .frame_err(frame_err));

   uart_alu_if #(.DBIT(8), .OP_W(6), .TIMEOUT(0), .TO_BITS(10)) dut0 (
      .clk(clk), .reset(reset), .rx_empty(rx_empty0), .r_data(r_data0), .rd_uart(rd_uart0),
      .tx_full(tx_full0), .wr_uart(wr_uart0), .w_data(w_data0), .alu_result(alu_res0),
      .op_a(op_a0), .op_b(op_b0), .op_code(op_code0), .busy(busy0), .frame_err(frame_err0));

   logic [7:0] rxq[$];
   logic [7:0] wlog[$];
   logic       txf = 1'b0;
   int cyc = 0, pop_cyc = 0, fe_cyc = 0;
   int rd_cnt = 0, wr_cnt = 0, fe_cnt = 0, rd0_cnt = 0, wr0_cnt = 0, fe0_cnt = 0;
   logic [7:0] w0_last = 8'h00;
   int n_vec = 0, n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: head/flags change only at negedge; strobes are sampled just after.
   always @(negedge clk) begin
      rx_empty = (rxq.size() == 0);
      r_data   = rx_empty ? 8'h00 : rxq[0];
      tx_full  = txf;
      #1;
      if (rd_uart) begin void'(rxq.pop_front()); rd_cnt++; pop_cyc = cyc + 1; end
      if (wr_uart) begin wr_cnt++; wlog.push_back(w_data); end
      if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (rd_uart0) rd0_cnt++;
      if (wr_uart0) begin wr0_cnt++; w0_last = w_data0; end
      if (frame_err0) fe0_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_wr(input int target, input int budget);
      for (int i = 0; i < budget && wr_cnt < target; i++) tick();
   endtask

   typedef struct {
      logic [7:0] a, b, op;
      logic [5:0] opc;
      logic [7:0] res;
   } vec_t;
   vec_t vt[7];

   initial begin
      int rd0, wr0, fe0;
      vt[0] = '{a:8'h05, b:8'h03, op:8'h20, opc:6'h20, res:8'h08};
      vt[1] = '{a:8'hFF, b:8'h01, op:8'h20, opc:6'h20, res:8'h00};
      vt[2] = '{a:8'h10, b:8'h20, op:8'h22, opc:6'h22, res:8'hF0};
      vt[3] = '{a:8'hF0, b:8'h3C, op:8'h24, opc:6'h24, res:8'h30};
      vt[4] = '{a:8'hA5, b:8'h5A, op:8'h3F, opc:6'h3F, res:8'hFF};
      vt[5] = '{a:8'h07, b:8'h09, op:8'hE0, opc:6'h20, res:8'h10};
      vt[6] = '{a:8'h00, b:8'h01, op:8'h22, opc:6'h22, res:8'hFF};

      // reset state, with a byte waiting that must not be popped
      rxq.push_back(8'h99);
      tick(3);
      check("rst_busy", busy, 0);
      check("rst_op_a", op_a, 0);
      check("rst_w_data", w_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_rd_uart", rd_uart, 0);
      check("rst_rd_cnt", rd_cnt, 0);
      rxq.delete();
      tick(2);
      reset = 1'b1;
      tick(2);

      // table of single frames
      foreach (vt[i]) begin
         rd0 = rd_cnt; wr0 = wr_cnt;
         rxq.push_back(vt[i].a); rxq.push_back(vt[i].b); rxq.push_back(vt[i].op);
         wait_wr(wr0 + 1, 30);
         tick(2);
         check($sformatf("vec%0d_wr_cnt", i), wr_cnt - wr0, 1);
         check($sformatf("vec%0d_rd_cnt", i), rd_cnt - rd0, 3);
         check($sformatf("vec%0d_w_data", i), wlog[wlog.size()-1], vt[i].res);
         check($sformatf("vec%0d_op_a", i), op_a, vt[i].a);
         check($sformatf("vec%0d_op_code", i), op_code, vt[i].opc);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end

      // TX full stall in S_SEND with an extra byte waiting in RX
      rd0 = rd_cnt; wr0 = wr_cnt;
      txf = 1'b1;
      rxq.push_back(8'h40); rxq.push_back(8'h02); rxq.push_back(8'h22); rxq.push_back(8'h77);
      for (int i = 0; i < 20 && rd_cnt < rd0 + 3; i++) tick();
      tick(50);
      check("stall_rd_cnt", rd_cnt - rd0, 3);
      check("stall_wr_cnt", wr_cnt - wr0, 0);
      check("stall_busy", busy, 1);
      check("stall_w_data", w_data, 8'h3E);
      txf = 1'b0;
      tick(1);
      check("stall_release_wr", wr_cnt - wr0, 1);
      check("stall_release_data", wlog[wlog.size()-1], 8'h3E);
      rxq.push_back(8'h01); rxq.push_back(8'h20);
      wait_wr(wr0 + 2, 30);
      tick(2);
      check("stall_next_frame", wlog[wlog.size()-1], 8'h78);

      // byte arriving on the last allowed cycle is popped, no timeout
      fe0 = fe_cnt; wr0 = wr_cnt;
      rxq.push_back(8'h11);
      tick(3);
      for (int i = 0; i < TO + 10 && cyc < pop_cyc + TO - 1; i++) tick();
      rxq.push_back(8'h5A);
      tick(5);
      check("edge_no_frame_err", fe_cnt - fe0, 0);
      check("edge_op_b", op_b, 8'h5A);
      rxq.push_back(8'h20);
      wait_wr(wr0 + 1, 30);
      tick(2);
      check("edge_result", wlog[wlog.size()-1], 8'h6B);

      // plain timeout: partial frame dropped, operands kept
      fe0 = fe_cnt; wr0 = wr_cnt;
      rxq.push_back(8'h11);
      for (int i = 0; i < TO + 50 && fe_cnt == fe0; i++) tick();
      tick(20);
      check("to_frame_err_cnt", fe_cnt - fe0, 1);
      check("to_frame_err_cycle", fe_cyc - pop_cyc, TO);
      check("to_busy", busy, 0);
      check("to_op_a_kept", op_a, 8'h11);
      rxq.push_back(8'h22);
      tick(3);
      check("to_next_op_a", op_a, 8'h22);
      rxq.push_back(8'h33); rxq.push_back(8'h20);
      wait_wr(wr0 + 1, 30);
      tick(2);
      check("to_next_result", wlog[wlog.size()-1], 8'h55);

      // two frames preloaded back to back
      rd0 = rd_cnt; wr0 = wr_cnt;
      rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h20);
      rxq.push_back(8'h30); rxq.push_back(8'h10); rxq.push_back(8'h22);
      wait_wr(wr0 + 2, 60);
      tick(5);
      check("b2b_rd_cnt", rd_cnt - rd0, 6);
      check("b2b_wr_cnt", wr_cnt - wr0, 2);
      check("b2b_first", wlog[wlog.size()-2], 8'h03);
      check("b2b_second", wlog[wlog.size()-1], 8'h20);

      // async reset while waiting for the opcode
      rd0 = rd_cnt; wr0 = wr_cnt;
      rxq.push_back(8'h44); rxq.push_back(8'h55);
      for (int i = 0; i < 20 && rd_cnt < rd0 + 2; i++) tick();
      tick(1);
      check("mid_busy_before", busy, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_op_a", op_a, 0);
      check("mid_rst_op_b", op_b, 0);
      check("mid_rst_op_code", op_code, 0);
      check("mid_rst_w_data", w_data, 0);
      rxq.push_back(8'h66); rxq.push_back(8'h01); rxq.push_back(8'h20);
      tick(2);
      check("mid_rst_rd_uart", rd_uart, 0);
      reset = 1'b1;
      tick(3);
      check("mid_after_op_a", op_a, 8'h66);
      wait_wr(wr0 + 1, 30);
      tick(2);
      check("mid_after_result", wlog[wlog.size()-1], 8'h67);
      check("mid_wr_cnt", wr_cnt - wr0, 1);

      // TIMEOUT=0 instance: long gaps never drop the frame
      r_data0 = 8'h09; rx_empty0 = 1'b0; tick(1); rx_empty0 = 1'b1;
      tick(10000);
      check("nto_frame_err", fe0_cnt, 0);
      check("nto_busy", busy0, 1);
      check("nto_op_a", op_a0, 8'h09);
      r_data0 = 8'h04; rx_empty0 = 1'b0; tick(1); rx_empty0 = 1'b1;
      tick(100);
      r_data0 = 8'h20; rx_empty0 = 1'b0; tick(1); rx_empty0 = 1'b1;
      tick(6);
      check("nto_rd_cnt", rd0_cnt, 3);
      check("nto_wr_cnt", wr0_cnt, 1);
      check("nto_result", w0_last, 8'h0D);
      check("nto_frame_err_end", fe0_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
